// File: rtl/wired0_defines.sv
// Shared pipeline definitions: ROB id width and the CDB result payload.
package wired0_defines;

    localparam int unsigned WID_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [WID_W-1:0]  wid;
        logic [DATA_W-1:0] data;
        logic              exc;
    } pipeline_cdb_t;

endpackage

// File: rtl/wired_rob_cpl_bank.sv
// One ROB bank (even or odd wids): done bits plus CDB payload, with one write,
// one read and one allocation-clear port.
module wired_rob_cpl_bank
    import wired0_defines::*;
#(
    parameter int unsigned IDX_W = WID_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  pipeline_cdb_t     wr_data_i,
    input  logic              clr_en_i,
    input  logic [IDX_W-1:0]  clr_idx_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_done_o,
    output pipeline_cdb_t     rd_data_o
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] done_d;
    pipeline_cdb_t    payload_q [DEPTH];

    // Allocation clear can never target the entry being written (ids are
    // only usable the cycle after grant), so ordering here is arbitrary.
    always_comb begin
        done_d = done_q;
        if (wr_en_i) begin
            done_d[wr_idx_i] = 1'b1;
        end
        if (clr_en_i) begin
            done_d[clr_idx_i] = 1'b0;
        end
        if (flush_i) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    // Payload is qualified by done, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_i && !flush_i) begin
            payload_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_done_o = done_q[rd_idx_i];
    assign rd_data_o = payload_q[rd_idx_i];

endmodule

// File: rtl/wired_rob_cpl.sv
// ROB completion/retirement tracker: in-order allocation, per-bank CDB absorb,
// and up to two in-order commits per cycle through a head-parity crossbar.
module wired_rob_cpl
    import wired0_defines::*;
#(
    parameter int unsigned ROB_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [1:0]                disp_valid_i,
    output logic                      disp_ready_o,
    output logic [1:0][WID_W-1:0]     disp_wid_o,
    input  pipeline_cdb_t [1:0]       cdb_i,
    output logic [1:0]                commit_valid_o,
    output pipeline_cdb_t [1:0]       commit_o,
    input  logic [1:0]                commit_ready_i
);

    localparam int unsigned PTR_W = WID_W + 1;
    localparam int unsigned IDX_W = WID_W - 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic             alloc0, alloc1;
    logic             ret0, ret1;
    logic [1:0]       done_h;

    logic [1:0]       bk_wr_en;
    logic [IDX_W-1:0] bk_wr_idx  [2];
    logic [1:0]       bk_clr_en;
    logic [IDX_W-1:0] bk_clr_idx [2];
    logic [IDX_W-1:0] bk_rd_idx  [2];
    logic [1:0]       bk_rd_done;
    pipeline_cdb_t    bk_rd_data [2];

    assign count        = tail_q - head_q;
    assign disp_ready_o = (count <= PTR_W'(ROB_DEPTH - 2));
    assign disp_wid_o[0] = tail_q[WID_W-1:0];
    assign disp_wid_o[1] = tail_q[WID_W-1:0] + WID_W'(1);

    assign alloc0 = disp_valid_i[0] & disp_ready_o;
    assign alloc1 = alloc0 & disp_valid_i[1];

    // Slot k lives in bank k ^ ptr[0]; bank 0 holds the later slot when ptr is odd.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bk_wr_en[b]  = cdb_i[b].valid;
            bk_wr_idx[b] = cdb_i[b].wid[WID_W-1:1];
        end
        bk_clr_idx[0] = tail_q[WID_W-1:1] + IDX_W'(tail_q[0]);
        bk_clr_idx[1] = tail_q[WID_W-1:1];
        bk_clr_en[0]  = tail_q[0] ? alloc1 : alloc0;
        bk_clr_en[1]  = tail_q[0] ? alloc0 : alloc1;
        bk_rd_idx[0]  = head_q[WID_W-1:1] + IDX_W'(head_q[0]);
        bk_rd_idx[1]  = head_q[WID_W-1:1];
    end

    always_comb begin
        commit_o[0] = head_q[0] ? bk_rd_data[1] : bk_rd_data[0];
        commit_o[1] = head_q[0] ? bk_rd_data[0] : bk_rd_data[1];
        done_h[0]   = head_q[0] ? bk_rd_done[1] : bk_rd_done[0];
        done_h[1]   = head_q[0] ? bk_rd_done[0] : bk_rd_done[1];
        commit_valid_o[0] = (count != '0) && done_h[0];
        commit_valid_o[1] = commit_valid_o[0] && (count >= PTR_W'(2)) && done_h[1];
    end

    assign ret0 = commit_valid_o[0] & commit_ready_i[0];
    assign ret1 = ret0 & commit_valid_o[1] & commit_ready_i[1];

    always_comb begin
        head_d = head_q + PTR_W'(ret0) + PTR_W'(ret1);
        tail_d = tail_q + PTR_W'(alloc0) + PTR_W'(alloc1);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        wired_rob_cpl_bank #(
            .IDX_W (IDX_W)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush_i),
            .wr_en_i   (bk_wr_en[g]),
            .wr_idx_i  (bk_wr_idx[g]),
            .wr_data_i (cdb_i[g]),
            .clr_en_i  (bk_clr_en[g]),
            .clr_idx_i (bk_clr_idx[g]),
            .rd_idx_i  (bk_rd_idx[g]),
            .rd_done_o (bk_rd_done[g]),
            .rd_data_o (bk_rd_data[g])
        );
    end

    // CDB results must land in their own bank and on an allocated id.
    for (genvar g = 0; g < 2; g++) begin : g_chk
        logic [WID_W-1:0] cdb_off;
        assign cdb_off = cdb_i[g].wid - head_q[WID_W-1:0];

        a_cdb_bank : assert property (@(posedge clk) disable iff (!rst_n)
            cdb_i[g].valid |-> (cdb_i[g].wid[0] == 1'(g)));
        a_cdb_alloc : assert property (@(posedge clk) disable iff (!rst_n)
            cdb_i[g].valid |-> (PTR_W'(cdb_off) < count));
    end

endmodule

// File: tb/tb_wired_rob_cpl.sv
// Bench for wired_rob_cpl: directed scenarios plus randomized traffic against
// a queue-level ROB model (head/tail counters, done flags, payload array).
module tb_wired_rob_cpl;
    import wired0_defines::*;

    localparam int DEPTH = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic [1:0]            dv;
    logic                  disp_ready;
    logic [1:0][WID_W-1:0] disp_wid;
    pipeline_cdb_t [1:0]   cdb;
    logic [1:0]            cv;
    pipeline_cdb_t [1:0]   co;
    logic [1:0]            cr;

    int checks   = 0;
    int failures = 0;

    int            m_head;
    int            m_tail;
    bit            m_done [DEPTH];
    pipeline_cdb_t m_pay  [DEPTH];

    always #5 clk = ~clk;

    wired_rob_cpl #(.ROB_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .disp_valid_i   (dv),
        .disp_ready_o   (disp_ready),
        .disp_wid_o     (disp_wid),
        .cdb_i          (cdb),
        .commit_valid_o (cv),
        .commit_o       (co),
        .commit_ready_i (cr)
    );

    // ---------------- reference model ----------------
    function automatic int m_count();
        return (m_tail - m_head + 2 * DEPTH) % (2 * DEPTH);
    endfunction

    function automatic bit m_ready();
        return (DEPTH - m_count()) >= 2;
    endfunction

    function automatic logic [1:0] m_valid();
        logic [1:0] v;
        int c;
        c = m_count();
        v[0] = (c >= 1) && m_done[m_head % DEPTH];
        v[1] = v[0] && (c >= 2) && m_done[(m_head + 1) % DEPTH];
        return v;
    endfunction

    task automatic model_apply();
        logic [1:0] v;
        int n_ret, n_alloc;
        if (!rst_n || flush) begin
            m_head = 0;
            m_tail = 0;
            foreach (m_done[i]) m_done[i] = 1'b0;
            return;
        end
        v = m_valid();
        n_ret   = (v[0] && cr[0]) ? ((v[1] && cr[1]) ? 2 : 1) : 0;
        n_alloc = (m_ready() && dv[0]) ? (dv[1] ? 2 : 1) : 0;
        for (int b = 0; b < 2; b++) begin
            if (cdb[b].valid) begin
                m_done[cdb[b].wid] = 1'b1;
                m_pay[cdb[b].wid]  = cdb[b];
            end
        end
        for (int i = 0; i < n_alloc; i++) m_done[(m_tail + i) % DEPTH] = 1'b0;
        m_head = (m_head + n_ret) % (2 * DEPTH);
        m_tail = (m_tail + n_alloc) % (2 * DEPTH);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic pipeline_cdb_t mk(int wid, logic [DATA_W-1:0] d);
        pipeline_cdb_t p;
        p.valid = 1'b1;
        p.wid   = WID_W'(wid);
        p.data  = d;
        p.exc   = d[0];
        return p;
    endfunction

    task automatic issue_cdb(int wid, logic [DATA_W-1:0] d);
        pipeline_cdb_t p;
        p = mk(wid, d);
        cdb[p.wid[0]] = p;
    endtask

    task automatic idle();
        dv    = 2'b00;
        cdb   = '0;
        cr    = 2'b00;
        flush = 1'b0;
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (cv !== 2'b00) begin
            failures++; $display("FAIL reset_commit_valid got=%b exp=00", cv);
        end
        checks++;
        if (disp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready);
        end
        checks++;
        if (disp_wid !== {WID_W'(1), WID_W'(0)}) begin
            failures++; $display("FAIL reset_disp_wid got=%h exp={1,0}", disp_wid);
        end
    endtask

    task automatic test_dispatch();
        dv = 2'b11;
        step();
        checks++;
        if (disp_wid !== {WID_W'(3), WID_W'(2)}) begin
            failures++; $display("FAIL dispatch_wid got=%h exp={3,2}", disp_wid);
        end
        checks++;
        if (cv !== 2'b00) begin
            failures++; $display("FAIL dispatch_commit_valid got=%b exp=00", cv);
        end
    endtask

    task automatic test_ooo_complete();
        logic [DATA_W-1:0] d0, d1;
        d0 = $urandom;
        d1 = $urandom;
        issue_cdb(1, d1);
        step();
        checks++;
        if (cv !== 2'b00) begin
            failures++; $display("FAIL ooo_young_only got=%b exp=00", cv);
        end
        issue_cdb(0, d0);
        step();
        checks++;
        if (cv !== 2'b11) begin
            failures++; $display("FAIL ooo_both_done got=%b exp=11", cv);
        end
        checks++;
        if (co[0] !== mk(0, d0) || co[1] !== mk(1, d1)) begin
            failures++; $display("FAIL ooo_payload got=%h/%h exp=%h/%h", co[0], co[1], mk(0, d0), mk(1, d1));
        end
        cr = 2'b11;
        step();
        checks++;
        if (dut.head_q !== 7'd2 || cv !== 2'b00) begin
            failures++; $display("FAIL ooo_retire head=%0d cv=%b exp head=2 cv=00", dut.head_q, cv);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 31; i++) begin
            dv = 2'b11;
            step();
        end
        checks++;
        if (dut.tail_q !== 7'd64 || disp_ready !== 1'b1) begin
            failures++; $display("FAIL fill62 tail=%0d rdy=%b exp tail=64 (wrapped) rdy=1", dut.tail_q, disp_ready);
        end
        dv = 2'b01;
        step();
        checks++;
        if (disp_ready !== 1'b0) begin
            failures++; $display("FAIL fill63_ready got=%b exp=0", disp_ready);
        end
        dv = 2'b11;
        step();
        checks++;
        if (dut.tail_q !== 7'd65) begin
            failures++; $display("FAIL fill63_blocked tail=%0d exp=65", dut.tail_q);
        end
        issue_cdb(2, $urandom);
        step();
        cr = 2'b01;
        dv = 2'b11;
        step();
        checks++;
        if (disp_ready !== 1'b1 || dut.head_q !== 7'd3 || dut.tail_q !== 7'd65) begin
            failures++; $display("FAIL retire_frees rdy=%b head=%0d tail=%0d exp rdy=1 head=3 tail=65", disp_ready, dut.head_q, dut.tail_q);
        end
        dv = 2'b11;
        step();
        checks++;
        if (disp_ready !== 1'b0 || dut.tail_q !== 7'd67) begin
            failures++; $display("FAIL full64 rdy=%b tail=%0d exp rdy=0 tail=67", disp_ready, dut.tail_q);
        end
        issue_cdb(3, $urandom);
        issue_cdb(4, $urandom);
        step();
        cr = 2'b11;
        step();
        checks++;
        if (disp_ready !== 1'b1 || dut.head_q !== 7'd5) begin
            failures++; $display("FAIL full_retire2 rdy=%b head=%0d exp rdy=1 head=5", disp_ready, dut.head_q);
        end
    endtask

    task automatic test_odd_head();
        logic [DATA_W-1:0] da, db;
        da = $urandom;
        db = $urandom;
        issue_cdb(5, da);
        issue_cdb(6, db);
        step();
        checks++;
        if (cv !== 2'b11) begin
            failures++; $display("FAIL odd_valid got=%b exp=11", cv);
        end
        checks++;
        if (co[0].wid !== WID_W'(5) || co[0].data !== da || co[1].wid !== WID_W'(6) || co[1].data !== db) begin
            failures++; $display("FAIL odd_crossbar got=%0d:%h/%0d:%h exp=5:%h/6:%h", co[0].wid, co[0].data, co[1].wid, co[1].data, da, db);
        end
    endtask

    task automatic test_partial_ready();
        cr = 2'b10;
        step();
        checks++;
        if (dut.head_q !== 7'd5 || cv !== 2'b11) begin
            failures++; $display("FAIL ready10 head=%0d cv=%b exp head=5 cv=11", dut.head_q, cv);
        end
        cr = 2'b01;
        step();
        checks++;
        if (dut.head_q !== 7'd6 || co[0].wid !== WID_W'(6) || cv !== 2'b01) begin
            failures++; $display("FAIL ready01 head=%0d wid=%0d cv=%b exp head=6 wid=6 cv=01", dut.head_q, co[0].wid, cv);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        dv = 2'b11;
        step();
        dv = 2'b11;
        step();
        issue_cdb(0, $urandom);
        step();
        checks++;
        if (cv !== 2'b01) begin
            failures++; $display("FAIL preflush_valid got=%b exp=01", cv);
        end
        dv = 2'b11;
        issue_cdb(3, $urandom);
        cr = 2'b01;
        flush = 1'b1;
        step();
        checks++;
        if (dut.head_q !== 7'd0 || dut.tail_q !== 7'd0 || cv !== 2'b00 || disp_ready !== 1'b1 ||
            disp_wid !== {WID_W'(1), WID_W'(0)}) begin
            failures++; $display("FAIL flush_state head=%0d tail=%0d cv=%b rdy=%b wid=%h exp 0/0/00/1/{1,0}",
                                 dut.head_q, dut.tail_q, cv, disp_ready, disp_wid);
        end
        dv = 2'b11;
        step();
        dv = 2'b11;
        step();
        issue_cdb(0, $urandom);
        issue_cdb(1, $urandom);
        step();
        cr = 2'b11;
        issue_cdb(2, $urandom);
        step();
        checks++;
        if (dut.head_q !== 7'd2 || cv !== 2'b01 || co[0].wid !== WID_W'(2)) begin
            failures++; $display("FAIL flush_stale_done head=%0d cv=%b wid=%0d exp head=2 cv=01 wid=2", dut.head_q, cv, co[0].wid);
        end
        rst_n = 1'b0;
        dv = 2'b11;
        step();
        rst_n = 1'b1;
        checks++;
        if (dut.head_q !== 7'd0 || dut.tail_q !== 7'd0 || cv !== 2'b00 || disp_ready !== 1'b1) begin
            failures++; $display("FAIL midop_reset head=%0d tail=%0d cv=%b rdy=%b exp 0/0/00/1", dut.head_q, dut.tail_q, cv, disp_ready);
        end
    endtask

    task automatic test_random();
        logic [1:0] ev;
        int r, c, id;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ev = m_valid();
            checks++;
            if (disp_ready !== m_ready()) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, disp_ready, m_ready());
            end
            checks++;
            if (disp_wid !== {WID_W'((m_tail + 1) % DEPTH), WID_W'(m_tail % DEPTH)}) begin
                failures++; $display("FAIL rnd_wid cyc=%0d got=%h exp_tail=%0d", cyc, disp_wid, m_tail);
            end
            checks++;
            if (cv !== ev) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, cv, ev);
            end
            for (int k = 0; k < 2; k++) begin
                if (ev[k]) begin
                    checks++;
                    if (co[k] !== m_pay[(m_head + k) % DEPTH]) begin
                        failures++; $display("FAIL rnd_payload cyc=%0d slot=%0d got=%h exp=%h", cyc, k, co[k], m_pay[(m_head + k) % DEPTH]);
                    end
                end
            end
            checks++;
            if (dut.head_q !== 7'(m_head) || dut.tail_q !== 7'(m_tail)) begin
                failures++; $display("FAIL rnd_ptrs cyc=%0d head=%0d tail=%0d exp=%0d/%0d", cyc, dut.head_q, dut.tail_q, m_head, m_tail);
            end
            r  = $urandom_range(0, 3);
            dv = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            cr = 2'($urandom_range(0, 3));
            c  = m_count();
            if (c > 0) begin
                for (int t = 0; t < 6; t++) begin
                    id = (m_head + $urandom_range(0, c - 1)) % DEPTH;
                    if (!m_done[id] && !cdb[id % 2].valid) issue_cdb(id, $urandom);
                end
            end
            flush = ($urandom_range(0, 63) == 0);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_dispatch();
        test_ooo_complete();
        test_fill_wrap();
        test_odd_head();
        test_partial_ready();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
